mem_access_ctrl: RTL

- Memory-side controller directly downstream of the memory data register.
- Accepts single-word read/write requests from the control unit, using the address from the address register and write data from the MDR's datain.
- Models a wait-stated 16-bit memory array.
- Returns read data plus the strobe the MDR uses to capture Dataout, with a busy/done handshake back to the control unit.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_array.sv | 37 +++
 rtl/mem_access_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-stated memory access controller.
package mem_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Exactly one of read/write asserted forms a legal request.
    function automatic logic single_req(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between the control unit / MDR side and the memory controller.
interface mem_access_ctrl_if
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
);
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              mem_bus;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output rd_req, wr_req, addr, wdata,
        input  rdata, mem_bus, busy, done, err
    );

    modport slave (
        input  rd_req, wr_req, addr, wdata,
        output rdata, mem_bus, busy, done, err
    );
endinterface

// File: rtl/mem_array.sv
// Single-port word array with synchronous write and a registered, resettable read port.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage: contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register: only a completed read may change it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side controller: captures one read/write request, waits WAIT_CYCLES,
// performs the array access and pulses done (and mem_bus for reads).
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W      = MEM_DATA_W,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_ctrl_if.slave    bus
);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_e            r_state;
    state_e            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    op_e               r_op;
    logic              w_capture;
    logic              w_illegal;
    logic              w_we;
    logic              w_re;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_bus;
    logic              r_err;
    logic [DATA_W-1:0] w_rdata;

    // State, counter and handshake output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mem_bus <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_busy    <= (w_next_state != IDLE);
            r_done    <= (w_next_state == RESP);
            r_mem_bus <= (w_next_state == RESP) && (r_op == OP_RD);
            r_err     <= w_illegal;
        end
    end

    // Request capture: held for the whole operation regardless of input changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_RD;
        end else if (w_capture) begin
            r_addr <= bus.addr;
            r_op   <= bus.wr_req ? OP_WR : OP_RD;
            if (bus.wr_req) begin
                r_wdata <= bus.wdata;
            end
        end
    end

    // Next-state, counter and array strobes.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_illegal    = 1'b0;
        w_we         = 1'b0;
        w_re         = 1'b0;
        case (r_state)
            IDLE: begin
                if (single_req(bus.rd_req, bus.wr_req)) begin
                    w_next_state = ACCESS;
                    w_cnt_next   = WAIT_INIT;
                    w_capture    = 1'b1;
                end else if (bus.rd_req && bus.wr_req) begin
                    w_illegal = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_we         = (r_op == OP_WR);
                    w_re         = (r_op == OP_RD);
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.rdata   = w_rdata;
    assign bus.mem_bus = r_mem_bus;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;

endmodule
